cmd_parser: RTL and testbench
=============================

// Module: cmd_parser
// PURPOSE
//   Parametrised keypad-command parser for the calculator front end: turns the
//   stream of IC_* key codes into one ALU request {src, alu_op, dst}.
//   Generalised over operand width, digit count and radix; adds backspace, clear,
//   overflow reporting and a valid/ready handshake on both sides.
//   Sits between the keypad decoder and the ALU/register-file control.
// PARAMETERS
//   DATA_W   16  operand width in bits (src, dst, accumulator)
//   MAX_DIG  3   max digits per operand; further digits rejected
//   RADIX    10  number base, 2..10; digit codes >= RADIX are rejected
// PORTS
//   Clock       in   1       single clock, rising edge
//   Reset       in   1       asynchronous, active-high; clears all state
//   cmd         in   IC_N    key code (IC_NUM0..9, IC_OP*, IC_CTOK, IC_BKSP, IC_CLR)
//   cmd_valid   in   1       cmd present this cycle
//   cmd_ready   out  1       parser accepts cmd; = (state != S_WAIT), combinational
//   src         out  DATA_W  source operand (valid when src_ans = 0)
//   src_ans     out  1       source is previous answer
//   dst         out  DATA_W  second operand (valid when dst_ans = 0)
//   dst_ans     out  1       second operand is previous answer
//   alu_op      out  IC_N    selected operator code
//   op_valid    out  1       request {src,src_ans,alu_op,dst,dst_ans} valid; held until op_ready
//   op_ready    in   1       ALU takes request
//   ovf         out  1       one-cycle pulse: a digit was rejected
// BEHAVIOUR
//   Reset: state S_IDLE; src=dst=0; src_ans=dst_ans=1; alu_op=IC_OPAN; op_valid=0; ovf=0; acc=0, cnt=0.
//   Accept = cmd_valid & cmd_ready; non-accepted cycles change nothing. Unknown codes ignored.
//   Digit append: acc*RADIX+d computed in DATA_W+4 bits; rejected (acc unchanged, ovf=1 next
//     cycle) if cnt==MAX_DIG or result > 2^DATA_W-1; else acc<=result, cnt++.
//   Backspace: acc<=acc/RADIX, cnt--.
//   S_IDLE: digit -> acc=d,cnt=1,S_SRC. op -> alu_op=cmd,src_ans=1,S_OPER. CLR/CTOK/BKSP ignored.
//   S_SRC : digit -> append. BKSP -> backspace; cnt reaching 0 -> S_IDLE.
//           op -> src=acc,src_ans=0,alu_op=cmd,acc=0,cnt=0,S_OPER. CTOK ignored. CLR -> S_IDLE.
//   S_OPER: digit -> acc=d,cnt=1,S_DST. op -> alu_op=cmd (operator replaced).
//           CTOK -> dst_ans=1,op_valid=1,S_WAIT. BKSP ignored. CLR -> S_IDLE.
//   S_DST : digit -> append. BKSP -> backspace; cnt reaching 0 -> S_OPER.
//           CTOK -> dst=acc,dst_ans=0,op_valid=1,S_WAIT. op ignored. CLR -> S_IDLE.
//   S_WAIT: outputs frozen, op_valid=1, cmd_ready=0; op_ready=1 -> op_valid=0,acc=0,cnt=0,S_IDLE
//           next edge. No command can be accepted in the handoff cycle.
//   CLR anywhere except S_WAIT: acc=0,cnt=0,src_ans=dst_ans=1,S_IDLE; alu_op kept.
//   op_valid rises exactly one cycle after accepted CTOK; latency key->request = 1 clock.
//   Reset mid-operation: immediate async clear to reset values, pending request dropped.
//   Rejected digit does not change state or cnt; ovf never coincides with a state change.
// STRUCTURE
//   Shared include (INPUT_INTERFACE.v): IC_N and all IC_* codes incl. new IC_BKSP, IC_CLR.
//   Private localparams: state encoding S_IDLE/S_SRC/S_OPER/S_DST/S_WAIT (3 bits).
//   Sub-module digit_acc (#DATA_W,MAX_DIG,RADIX): acc, cnt, load/append/backspace/clear,
//     reject flag; cmd_parser owns FSM, operand/op registers and handshake.
// TESTING (DATA_W=16, MAX_DIG=3, RADIX=10 unless stated)
//   1,2,+,3,4,CTOK -> op_valid=1 src=12 dst=34 alu_op=IC_OPAD src_ans=dst_ans=0
//   idle: -,CTOK -> src_ans=1 dst_ans=1 alu_op=IC_OPSB; then op_ready -> S_IDLE, op_valid=0
//   9,9,9,9 -> ovf pulse on 4th, src=999 after +; DATA_W=8: 2,5,6 -> 6 rejected, acc=25
//   1,2,BKSP,7,+,5,BKSP,CTOK -> src=17, dst_ans=1; BKSP in S_SRC at cnt=1 -> S_IDLE
//   op_ready low 5 cycles in S_WAIT: cmd_ready=0, keys ignored, outputs stable; then handoff
//   Reset pulse mid S_DST (acc=34) -> outputs return to reset values without a clock edge

Source files
------------

// File: rtl/cmd_parser_pkg.sv
// Key codes and key classes shared by the keypad
// front end, the command parser and its testbench.
package cmd_parser_pkg;

    localparam int IC_N = 5;

    typedef logic [IC_N-1:0] ic_t;

    localparam ic_t IC_NUM0 = 5'd0;
    localparam ic_t IC_NUM1 = 5'd1;
    localparam ic_t IC_NUM2 = 5'd2;
    localparam ic_t IC_NUM3 = 5'd3;
    localparam ic_t IC_NUM4 = 5'd4;
    localparam ic_t IC_NUM5 = 5'd5;
    localparam ic_t IC_NUM6 = 5'd6;
    localparam ic_t IC_NUM7 = 5'd7;
    localparam ic_t IC_NUM8 = 5'd8;
    localparam ic_t IC_NUM9 = 5'd9;
    localparam ic_t IC_OPAD = 5'd10;
    localparam ic_t IC_OPSB = 5'd11;
    localparam ic_t IC_OPAN = 5'd12;
    localparam ic_t IC_OPOR = 5'd13;
    localparam ic_t IC_OPXR = 5'd14;
    localparam ic_t IC_CTOK = 5'd15;
    localparam ic_t IC_BKSP = 5'd16;
    localparam ic_t IC_CLR  = 5'd17;

    typedef enum logic [2:0] {
        K_NONE,
        K_DIG,
        K_OP,
        K_CTOK,
        K_BKSP,
        K_CLR
    } key_t;

    // Codes outside every class map to K_NONE and are ignored
    function automatic key_t key_class(ic_t c);
        key_t k;
        k = K_NONE;
        unique case (1'b1)
            (c <= IC_NUM9):                 k = K_DIG;
            (c >= IC_OPAD && c <= IC_OPXR): k = K_OP;
            (c == IC_CTOK):                 k = K_CTOK;
            (c == IC_BKSP):                 k = K_BKSP;
            (c == IC_CLR):                  k = K_CLR;
            default:                        k = K_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/cmd_parser_if.sv
// Key stream in, ALU request out, each side with
// its own valid/ready pair.
interface cmd_parser_if #(
    parameter int DATA_W = 16
);
    import cmd_parser_pkg::*;

    ic_t               cmd;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] src;
    logic              src_ans;
    logic [DATA_W-1:0] dst;
    logic              dst_ans;
    ic_t               alu_op;
    logic              op_valid;
    logic              op_ready;
    logic              ovf;

    modport master (
        output cmd, cmd_valid, op_ready,
        input  cmd_ready, src, src_ans, dst,
        input  dst_ans, alu_op, op_valid, ovf
    );

    modport slave (
        input  cmd, cmd_valid, op_ready,
        output cmd_ready, src, src_ans, dst,
        output dst_ans, alu_op, op_valid, ovf
    );

endinterface

// File: rtl/cmd_parser_digit_acc.sv
// Operand accumulator: load, append, backspace and
// clear, with a reject flag for digits that do not fit.
module cmd_parser_digit_acc #(
    parameter int DATA_W  = 16,
    parameter int MAX_DIG = 3,
    parameter int RADIX   = 10,
    parameter int CNT_W   = $clog2(MAX_DIG + 1)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              load,
    input  logic              append,
    input  logic              bksp,
    input  logic              clear,
    input  logic [3:0]        d,
    output logic [DATA_W-1:0] acc,
    output logic [CNT_W-1:0]  cnt,
    output logic              reject
);

    localparam int XW = DATA_W + 4;

    logic [XW-1:0] prod;
    logic          bad_d;
    logic          full;
    logic          big;

    // Four spare bits hold acc*RADIX+d for any RADIX up to 10
    always_comb begin
        prod   = {4'd0, acc} * XW'(RADIX) + XW'(d);
        bad_d  = {28'd0, d} >= 32'(RADIX);
        full   = cnt == CNT_W'(MAX_DIG);
        big    = |prod[XW-1:DATA_W];
        reject = (load & bad_d)
               | (append & (bad_d | full | big));
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (load && !bad_d) begin
            acc <= DATA_W'(d);
            cnt <= CNT_W'(1);
        end else if (append && !reject) begin
            acc <= prod[DATA_W-1:0];
            cnt <= cnt + CNT_W'(1);
        end else if (bksp) begin
            acc <= acc / DATA_W'(RADIX);
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/cmd_parser.sv
// Keypad command parser: folds key codes into one
// {src, alu_op, dst} request for the ALU.
module cmd_parser
    import cmd_parser_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int MAX_DIG = 3,
    parameter int RADIX   = 10
) (
    input  logic         Clock,
    input  logic         Reset,
    cmd_parser_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_DIG + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SRC  = 3'd1;
    localparam logic [2:0] S_OPER = 3'd2;
    localparam logic [2:0] S_DST  = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;

    logic [2:0]        state;
    logic [DATA_W-1:0] src_q;
    logic [DATA_W-1:0] dst_q;
    logic              src_ans_q;
    logic              dst_ans_q;
    ic_t               alu_op_q;
    logic              op_valid_q;
    logic              ovf_q;

    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              rej;
    logic              ld, app, bk, clr;
    logic              rdy, acpt, last_dig;
    key_t              kc;

    assign rdy      = state != S_WAIT;
    assign acpt     = bus.cmd_valid & rdy;
    assign kc       = acpt ? key_class(bus.cmd) : K_NONE;
    assign last_dig = cnt == CNT_W'(1);

    always_comb begin
        ld  = 1'b0;
        app = 1'b0;
        bk  = 1'b0;
        clr = 1'b0;
        unique case (state)
            S_IDLE: ld = kc == K_DIG;
            S_SRC: begin
                app = kc == K_DIG;
                bk  = kc == K_BKSP;
                clr = kc == K_OP || kc == K_CLR;
            end
            S_OPER: begin
                ld  = kc == K_DIG;
                clr = kc == K_CLR;
            end
            S_DST: begin
                app = kc == K_DIG;
                bk  = kc == K_BKSP;
                clr = kc == K_CLR;
            end
            S_WAIT:  clr = bus.op_ready;
            default: clr = 1'b0;
        endcase
    end

    cmd_parser_digit_acc #(
        .DATA_W  (DATA_W),
        .MAX_DIG (MAX_DIG),
        .RADIX   (RADIX),
        .CNT_W   (CNT_W)
    ) u_acc (
        .Clock  (Clock),
        .Reset  (Reset),
        .load   (ld),
        .append (app),
        .bksp   (bk),
        .clear  (clr),
        .d      (bus.cmd[3:0]),
        .acc    (acc),
        .cnt    (cnt),
        .reject (rej)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            src_ans_q  <= 1'b1;
            dst_ans_q  <= 1'b1;
            alu_op_q   <= IC_OPAN;
            op_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ovf_q <= (ld | app) & rej;
            unique case (state)
                S_IDLE: begin
                    if (kc == K_DIG && !rej) begin
                        state <= S_SRC;
                    end else if (kc == K_OP) begin
                        alu_op_q  <= bus.cmd;
                        src_ans_q <= 1'b1;
                        state     <= S_OPER;
                    end
                end
                S_SRC: begin
                    if (kc == K_BKSP && last_dig) begin
                        state <= S_IDLE;
                    end else if (kc == K_OP) begin
                        src_q     <= acc;
                        src_ans_q <= 1'b0;
                        alu_op_q  <= bus.cmd;
                        state     <= S_OPER;
                    end else if (kc == K_CLR) begin
                        src_ans_q <= 1'b1;
                        dst_ans_q <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_OPER: begin
                    if (kc == K_DIG && !rej) begin
                        state <= S_DST;
                    end else if (kc == K_OP) begin
                        alu_op_q <= bus.cmd;
                    end else if (kc == K_CTOK) begin
                        dst_ans_q  <= 1'b1;
                        op_valid_q <= 1'b1;
                        state      <= S_WAIT;
                    end else if (kc == K_CLR) begin
                        src_ans_q <= 1'b1;
                        dst_ans_q <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_DST: begin
                    if (kc == K_BKSP && last_dig) begin
                        state <= S_OPER;
                    end else if (kc == K_CTOK) begin
                        dst_q      <= acc;
                        dst_ans_q  <= 1'b0;
                        op_valid_q <= 1'b1;
                        state      <= S_WAIT;
                    end else if (kc == K_CLR) begin
                        src_ans_q <= 1'b1;
                        dst_ans_q <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (bus.op_ready) begin
                        op_valid_q <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = rdy;
    assign bus.src       = src_q;
    assign bus.src_ans   = src_ans_q;
    assign bus.dst       = dst_q;
    assign bus.dst_ans   = dst_ans_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.op_valid  = op_valid_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cmd_parser.sv
// Directed bench for cmd_parser: vector table plus
// hand-written overflow, stall and reset sequences.
module tb_cmd_parser;
    import cmd_parser_pkg::*;

    logic Clock;
    logic Reset;
    int   total;
    int   passed;

    cmd_parser_if #(.DATA_W(16)) b16 ();
    cmd_parser_if #(.DATA_W(8))  b8 ();

    assign b8.cmd       = b16.cmd;
    assign b8.cmd_valid = b16.cmd_valid;
    assign b8.op_ready  = b16.op_ready;

    cmd_parser #(
        .DATA_W(16), .MAX_DIG(3), .RADIX(10)
    ) u16 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (b16)
    );

    cmd_parser #(
        .DATA_W(8), .MAX_DIG(3), .RADIX(10)
    ) u8 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (b8)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        ic_t [0:7]   keys;
        int          n;
        logic [15:0] src;
        logic        src_ans;
        logic [15:0] dst;
        logic        dst_ans;
        ic_t         op;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d",
                      nm, act, exp);
    endtask

    task automatic press(input ic_t c);
        @(negedge Clock);
        b16.cmd       = c;
        b16.cmd_valid = 1'b1;
        @(negedge Clock);
        b16.cmd_valid = 1'b0;
    endtask

    task automatic handoff(input string nm);
        @(negedge Clock);
        b16.op_ready = 1'b1;
        @(negedge Clock);
        b16.op_ready = 1'b0;
        chk({nm, " op_valid drop"}, 32'(b16.op_valid), 0);
        chk({nm, " cmd_ready back"}, 32'(b16.cmd_ready), 1);
    endtask

    task automatic pulse_reset();
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " src"}, 32'(b16.src), 0);
        chk({nm, " dst"}, 32'(b16.dst), 0);
        chk({nm, " src_ans"}, 32'(b16.src_ans), 1);
        chk({nm, " dst_ans"}, 32'(b16.dst_ans), 1);
        chk({nm, " alu_op"}, 32'(b16.alu_op), 32'(IC_OPAN));
        chk({nm, " op_valid"}, 32'(b16.op_valid), 0);
        chk({nm, " ovf"}, 32'(b16.ovf), 0);
        chk({nm, " cmd_ready"}, 32'(b16.cmd_ready), 1);
    endtask

    initial begin
        ic_t stall[5];
        total  = 0;
        passed = 0;

        vt[0]  = '{'{IC_NUM1, IC_NUM2, IC_OPAD, IC_NUM3,
                     IC_NUM4, IC_CTOK, IC_NUM0, IC_NUM0},
                   6, 16'd12, 1'b0, 16'd34, 1'b0, IC_OPAD};
        vt[1]  = '{'{IC_OPSB, IC_CTOK, IC_NUM0, IC_NUM0,
                     IC_NUM0, IC_NUM0, IC_NUM0, IC_NUM0},
                   2, 16'd0, 1'b1, 16'd0, 1'b1, IC_OPSB};
        vt[2]  = '{'{IC_NUM1, IC_NUM2, IC_BKSP, IC_NUM7,
                     IC_OPAD, IC_NUM5, IC_BKSP, IC_CTOK},
                   8, 16'd17, 1'b0, 16'd0, 1'b1, IC_OPAD};
        vt[3]  = '{'{IC_NUM5, IC_OPAD, IC_OPSB, IC_NUM2,
                     IC_CTOK, IC_NUM0, IC_NUM0, IC_NUM0},
                   5, 16'd5, 1'b0, 16'd2, 1'b0, IC_OPSB};
        vt[4]  = '{'{IC_NUM5, IC_OPAD, IC_NUM3, IC_OPAN,
                     IC_CTOK, IC_NUM0, IC_NUM0, IC_NUM0},
                   5, 16'd5, 1'b0, 16'd3, 1'b0, IC_OPAD};
        vt[5]  = '{'{IC_NUM4, IC_CLR, IC_NUM6, IC_OPOR,
                     IC_NUM7, IC_CTOK, IC_NUM0, IC_NUM0},
                   6, 16'd6, 1'b0, 16'd7, 1'b0, IC_OPOR};
        vt[6]  = '{'{IC_NUM3, 5'd31, IC_OPAD, 5'd31,
                     IC_NUM8, IC_CTOK, IC_NUM0, IC_NUM0},
                   6, 16'd3, 1'b0, 16'd8, 1'b0, IC_OPAD};
        vt[7]  = '{'{IC_NUM4, IC_CTOK, IC_OPXR, IC_BKSP,
                     IC_NUM2, IC_NUM0, IC_CTOK, IC_NUM0},
                   7, 16'd4, 1'b0, 16'd20, 1'b0, IC_OPXR};
        vt[8]  = '{'{IC_NUM0, IC_NUM0, IC_NUM7, IC_OPAD,
                     IC_NUM1, IC_NUM0, IC_NUM0, IC_CTOK},
                   8, 16'd7, 1'b0, 16'd100, 1'b0, IC_OPAD};
        vt[9]  = '{'{IC_NUM1, IC_OPAD, IC_NUM2, IC_CLR,
                     IC_NUM8, IC_OPSB, IC_NUM9, IC_CTOK},
                   8, 16'd8, 1'b0, 16'd9, 1'b0, IC_OPSB};
        vt[10] = '{'{IC_NUM5, IC_BKSP, IC_OPAD, IC_CTOK,
                     IC_NUM0, IC_NUM0, IC_NUM0, IC_NUM0},
                   4, 16'd0, 1'b1, 16'd0, 1'b1, IC_OPAD};

        Reset         = 1'b1;
        b16.cmd       = IC_NUM0;
        b16.cmd_valid = 1'b0;
        b16.op_ready  = 1'b0;
        #12;
        chk_reset_vals("reset");
        @(negedge Clock);
        Reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            for (int j = 0; j < vt[i].n; j++)
                press(vt[i].keys[j]);
            chk({nm, " op_valid"}, 32'(b16.op_valid), 1);
            chk({nm, " cmd_ready"}, 32'(b16.cmd_ready), 0);
            chk({nm, " alu_op"}, 32'(b16.alu_op),
                32'(vt[i].op));
            chk({nm, " src_ans"}, 32'(b16.src_ans),
                32'(vt[i].src_ans));
            chk({nm, " dst_ans"}, 32'(b16.dst_ans),
                32'(vt[i].dst_ans));
            if (!vt[i].src_ans)
                chk({nm, " src"}, 32'(b16.src),
                    32'(vt[i].src));
            if (!vt[i].dst_ans)
                chk({nm, " dst"}, 32'(b16.dst),
                    32'(vt[i].dst));
            handoff(nm);
        end

        // Fourth digit overflows the three-digit limit
        press(IC_NUM9);
        press(IC_NUM9);
        press(IC_NUM9);
        chk("ovf quiet 3rd", 32'(b16.ovf), 0);
        press(IC_NUM9);
        chk("ovf pulse 4th", 32'(b16.ovf), 1);
        @(negedge Clock);
        chk("ovf one cycle", 32'(b16.ovf), 0);
        press(IC_OPAD);
        press(IC_CTOK);
        chk("ovf src", 32'(b16.src), 999);
        chk("ovf src_ans", 32'(b16.src_ans), 0);
        chk("ovf dst_ans", 32'(b16.dst_ans), 1);
        handoff("ovf");

        // 8-bit instance: 256 does not fit
        pulse_reset();
        press(IC_NUM2);
        press(IC_NUM5);
        chk("w8 ovf quiet", 32'(b8.ovf), 0);
        press(IC_NUM6);
        chk("w8 ovf pulse", 32'(b8.ovf), 1);
        press(IC_OPAD);
        press(IC_CTOK);
        chk("w8 src", 32'(b8.src), 25);
        chk("w8 op_valid", 32'(b8.op_valid), 1);
        chk("w16 src 256", 32'(b16.src), 256);
        handoff("w8");

        // Request held through a stalled ALU
        press(IC_NUM1);
        press(IC_OPAD);
        press(IC_NUM2);
        chk("lat before ctok", 32'(b16.op_valid), 0);
        press(IC_CTOK);
        chk("lat after ctok", 32'(b16.op_valid), 1);
        stall = '{IC_CLR, IC_NUM7, IC_BKSP, IC_OPSB, IC_CTOK};
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            b16.cmd       = stall[k];
            b16.cmd_valid = 1'b1;
            @(negedge Clock);
            chk($sformatf("stall%0d cmd_ready", k),
                32'(b16.cmd_ready), 0);
            chk($sformatf("stall%0d op_valid", k),
                32'(b16.op_valid), 1);
            chk($sformatf("stall%0d src", k),
                32'(b16.src), 1);
            chk($sformatf("stall%0d dst", k),
                32'(b16.dst), 2);
            chk($sformatf("stall%0d alu_op", k),
                32'(b16.alu_op), 32'(IC_OPAD));
        end
        b16.cmd_valid = 1'b0;
        handoff("stall");

        // Async reset while building the second operand
        press(IC_NUM1);
        press(IC_OPAD);
        press(IC_NUM3);
        press(IC_NUM4);
        #2 Reset = 1'b1;
        #1;
        chk_reset_vals("async dst");
        @(negedge Clock);
        Reset = 1'b0;

        // Async reset drops a pending request
        press(IC_NUM1);
        press(IC_OPAD);
        press(IC_NUM2);
        press(IC_CTOK);
        chk("pend op_valid", 32'(b16.op_valid), 1);
        #2 Reset = 1'b1;
        #1;
        chk("drop op_valid", 32'(b16.op_valid), 0);
        chk("drop cmd_ready", 32'(b16.cmd_ready), 1);
        @(negedge Clock);
        Reset = 1'b0;

        press(IC_NUM4);
        press(IC_OPSB);
        press(IC_NUM5);
        press(IC_CTOK);
        chk("post src", 32'(b16.src), 4);
        chk("post dst", 32'(b16.dst), 5);
        handoff("post");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
